// File: rtl/sigmoid_inverse_bisect.sv
// Bit-serial inverse sigmoid: 12-step bisection of Q1.12 y against a shift/add PLAN sigmoid, Q4.8 result.
// Optional SIGINV_EARLY_SAT_EN: saturated operands (y==0, y>=1.0) bypass the search.
module sigmoid_inverse_bisect #(
    parameter int unsigned XW = 12,
    parameter int unsigned YW = 13
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [YW-1:0] y_in,
    output logic          busy,
    output logic          valid_out,
    output logic [XW-1:0] x_out,
    output logic          sat_out
);

    localparam int unsigned KW = 4;
    localparam int unsigned PW = 14;
    localparam logic [PW-1:0] ONE = PW'(4096);

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

    state_t        state, state_n;
    logic [YW-1:0] y_r, y_n;
    logic [XW-1:0] u_r, u_n;
    logic [KW-1:0] k_r, k_n;
    logic          busy_n, valid_n, sat_n;
    logic [XW-1:0] x_n;

    logic [XW-1:0] trial_c, xc_c, a_c, u_keep_c;
    logic          neg_c, keep_c, sat_c;
    logic [PW-1:0] f_c, p_c;

    // PLAN sigmoid of the current trial code and the keep decision
    always_comb begin
        trial_c = u_r | (XW'(1) << k_r);
        xc_c    = {~trial_c[XW-1], trial_c[XW-2:0]};
        neg_c   = xc_c[XW-1];
        a_c     = neg_c ? (~xc_c + XW'(1)) : xc_c;
        if (a_c >= XW'(1280))
            f_c = ONE;
        else if (a_c >= XW'(608))
            f_c = PW'(a_c >> 1) + PW'(3456);
        else if (a_c >= XW'(256))
            f_c = (PW'(a_c) << 1) + PW'(2560);
        else
            f_c = (PW'(a_c) << 2) + PW'(2048);
        p_c = neg_c ? (ONE - f_c) : f_c;
        // PLAN dips just below |x|=2.375; clamp to the value reached past the dip so the
        // search stays monotone and lands on the largest x with P(x) <= y.
        if (!neg_c && (a_c < XW'(608)) && (p_c > PW'(3760)))
            p_c = PW'(3760);
        if (neg_c && (a_c >= XW'(608)) && (a_c < XW'(640)) && (p_c > PW'(322)))
            p_c = PW'(322);
        keep_c   = PW'(y_r) >= p_c;
        u_keep_c = keep_c ? trial_c : u_r;
        sat_c    = (y_r == '0) || (PW'(y_r) >= ONE);
    end

    // Next-state and next-output logic
    always_comb begin
        state_n = state;
        y_n     = y_r;
        u_n     = u_r;
        k_n     = k_r;
        busy_n  = busy;
        valid_n = 1'b0;
        x_n     = x_out;
        sat_n   = sat_out;
        unique case (state)
            IDLE: begin
                if (start) begin
                    y_n     = y_in;
                    u_n     = '0;
                    k_n     = KW'(XW - 1);
                    busy_n  = 1'b1;
                    state_n = SEARCH;
`ifdef SIGINV_EARLY_SAT_EN
                    if ((y_in == '0) || (PW'(y_in) >= ONE)) begin
                        u_n     = (y_in == '0) ? XW'(12'h300) : XW'(12'hFFF);
                        state_n = DONE;
                    end
`endif
                end
            end
            SEARCH: begin
                u_n = u_keep_c;
                k_n = k_r - KW'(1);
                if (k_r == '0) begin
                    state_n = DONE;
                    busy_n  = 1'b0;
                    valid_n = 1'b1;
                    x_n     = {~u_keep_c[XW-1], u_keep_c[XW-2:0]};
                    sat_n   = sat_c;
                end
            end
            DONE: begin
                state_n = IDLE;
`ifdef SIGINV_EARLY_SAT_EN
                // Early-saturation entry arrives with busy still set: publish, then hold DONE one cycle
                if (busy) begin
                    state_n = DONE;
                    busy_n  = 1'b0;
                    valid_n = 1'b1;
                    x_n     = {~u_r[XW-1], u_r[XW-2:0]};
                    sat_n   = sat_c;
                end
`endif
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            y_r       <= '0;
            u_r       <= '0;
            k_r       <= '0;
            busy      <= 1'b0;
            valid_out <= 1'b0;
            x_out     <= '0;
            sat_out   <= 1'b0;
        end else begin
            state     <= state_n;
            y_r       <= y_n;
            u_r       <= u_n;
            k_r       <= k_n;
            busy      <= busy_n;
            valid_out <= valid_n;
            x_out     <= x_n;
            sat_out   <= sat_n;
        end
    end

endmodule

// File: tb/tb_sigmoid_inverse_bisect.sv
// Scoreboard bench for sigmoid_inverse_bisect: reference is a brute-force "largest x with P(x) <= y".
module tb_sigmoid_inverse_bisect;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [12:0] y_in;
    logic        busy;
    logic        valid_out;
    logic [11:0] x_out;
    logic        sat_out;

    sigmoid_inverse_bisect dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .y_in      (y_in),
        .busy      (busy),
        .valid_out (valid_out),
        .x_out     (x_out),
        .sat_out   (sat_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          y;
        logic [11:0] x;
        logic        sat;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   sweep_mode = 1'b0;
    bit   prev_ok    = 1'b0;
    int   prev_x     = 0;

    task automatic check(input string name, input int act, input int exp, input int y);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s (y=%0d): got %0d (0x%0h), expected %0d (0x%0h)", name, y, act, act, exp, exp);
    endtask

    task automatic finish_run();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    endtask

    // Piecewise-linear sigmoid on real Q4.8 / Q1.12 integer values
    function automatic int p_of(input int x);
        int a, f;
        a = (x < 0) ? -x : x;
        if (a >= 1280)     f = 4096;
        else if (a >= 608) f = a / 2 + 3456;
        else if (a >= 256) f = 2 * a + 2560;
        else               f = 4 * a + 2048;
        return (x >= 0) ? f : 4096 - f;
    endfunction

    function automatic int ref_x(input int y);
        int ys;
        ys = (y > 4096) ? 4096 : y;
        for (int x = 2047; x >= -2048; x--)
            if (p_of(x) <= ys) return x;
        return -2048;
    endfunction

    function automatic logic sat_of(input int y);
        return (y == 0) || (y >= 4096);
    endfunction

    // Edges from the accepting edge to the edge that raises valid_out
    function automatic int lat_of(input int y);
`ifdef SIGINV_EARLY_SAT_EN
        if (sat_of(y)) return 1;
`endif
        return 12;
    endfunction

    // Monitor: compare every presented result against the scoreboard head
    exp_t e;
    always @(negedge clk) begin
        if (valid_out) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 1, 0, -1);
            end else begin
                e = sb.pop_front();
                check("x_out", int'(x_out), int'(e.x), e.y);
                check("sat_out", int'(sat_out), int'(e.sat), e.y);
                check("latency", cyc - e.acc, e.lat, e.y);
                check("busy_at_valid", int'(busy), 0, e.y);
                check("p_le_y", int'(p_of(int'($signed(x_out))) <= ((e.y > 4096) ? 4096 : e.y)), 1, e.y);
                if (sweep_mode) begin
                    if (prev_ok) check("monotone", int'(int'($signed(x_out)) >= prev_x), 1, e.y);
                    prev_x  = int'($signed(x_out));
                    prev_ok = 1'b1;
                end
            end
        end
    end

    // Issue one operand (optionally a stray start at edge acc+spur_at) and wait for its result
    task automatic run_one(input int y, input logic [11:0] ex, input int spur_at, input int spur_y);
        bit got;
        @(negedge clk);
        start = 1'b1;
        y_in  = 13'(y);
        @(negedge clk);
        start = 1'b0;
        y_in  = 13'($urandom);
        sb.push_back('{y: y, x: ex, sat: sat_of(y), acc: cyc, lat: lat_of(y)});
        check("busy_after_start", int'(busy), 1, y);
        got = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            start = (i == spur_at);
            if (i == spur_at) y_in = 13'(spur_y);
            @(negedge clk);
            if (valid_out) begin
                got = 1'b1;
                break;
            end
        end
        start = 1'b0;
        if (!got) begin
            check("result_timeout", 0, 1, y);
            finish_run();
        end
    endtask

    task automatic run_rand(input int y);
        int sp;
        sp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, lat_of(y))) : 0;
        run_one(y, 12'(ref_x(y)), sp, int'($urandom_range(0, 8191)));
        repeat ($urandom_range(0, 1)) @(negedge clk);
    endtask

    initial begin
        int nv;
        reset = 1'b1;
        start = 1'b0;
        y_in  = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0, -1);
        check("rst_valid", int'(valid_out), 0, -1);
        check("rst_x", int'(x_out), 0, -1);
        check("rst_sat", int'(sat_out), 0, -1);
        reset = 1'b0;

        // Directed: stray start during search, then start held in the DONE cycle
        run_one(2048, 12'h000, 5, 100);
        start = 1'b1;
        y_in  = 13'd100;
        @(negedge clk);
        start = 1'b0;
        check("start_in_done_ignored", int'(busy), 0, 100);
        repeat (15) @(negedge clk);

        // Directed back-to-back operands, including saturation corners
        run_one(3072, 12'h100, 0, 0);
        run_one(1024, 12'hF00, 0, 0);
        run_one(0,    12'hB00, 0, 0);
        run_one(4096, 12'h7FF, 0, 0);
        run_one(8191, 12'h7FF, 0, 0);
        run_one(3072, 12'h100, 0, 0);

        // Reset mid-search: outputs clear at once, no result follows
        @(negedge clk);
        start = 1'b1;
        y_in  = 13'd1024;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("busy_mid_search", int'(busy), 1, 1024);
        check("x_held_mid_search", int'(x_out), 'h100, 1024);
        #2 reset = 1'b1;
        #1;
        check("abort_busy", int'(busy), 0, 1024);
        check("abort_valid", int'(valid_out), 0, 1024);
        check("abort_x", int'(x_out), 0, 1024);
        check("abort_sat", int'(sat_out), 0, 1024);
        @(negedge clk);
        reset = 1'b0;
        nv = 0;
        repeat (20) begin
            @(negedge clk);
            if (valid_out) nv++;
        end
        check("valid_after_abort", nv, 0, 1024);

        // Full sweep of legal probabilities, then random operands over the whole input range
        sweep_mode = 1'b1;
        prev_ok    = 1'b0;
        for (int y = 0; y <= 4096; y++) run_rand(y);
        sweep_mode = 1'b0;
        for (int n = 0; n < 150; n++) run_rand(int'($urandom_range(0, 8191)));

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0, -1);
        finish_run();
    end

endmodule
